sd_receiver: RTL
================

# sd_receiver

Serial-data receiver for the LVDA/LVDC serial link: the receiving end of the switch-selector/data sampler path that drives the single `DATA` line bit-by-bit under bit-time gating. It samples the serial stream on a bit strobe, assembles a full word MSB-first, optionally checks an odd parity bit, and hands the word to the consumer through a one-deep holding register with a valid/ack handshake. It sits between the serial link and the LVDC input-register logic.

## Interface

Parameters:
- `WIDTH`, 26: data bits per word, excluding parity.

Ports:
- `SIM_CLK` in 1: simulation clock; every register updates on its rising edge.
- `SIM_RST` in 1: reset, asynchronous, active-high.
- `SER_DATA` in 1: serial data line. It is sampled only in a cycle where `BIT_STB` is 1.
- `BIT_STB` in 1: bit-time strobe, one cycle wide, one per serial bit.
- `WORD_STB` in 1: start-of-word marker. It is coincident with the `BIT_STB` of the first bit.
- `WORD_ACK` in 1: consumer accepts the held word.
- `ERR_CLR` in 1: clears the sticky error flags.
- `WORD` out WIDTH: the held word. The first received bit is in `WORD[WIDTH-1]`.
- `WORD_VALID` out 1: the held word is valid and unconsumed.
- `OVERRUN` out 1: sticky. A completed word was dropped because the holding register was full.
- `FRAME_ERR` out 1: sticky. `WORD_STB` arrived while a word was in progress.
- `PAR_ERR` out 1: sticky. The parity check failed. Present only with `SD_PARITY_EN`.

## Operation

- The FSM has two states, IDLE and SHIFT. Reset places it in IDLE with the bit counter at 0, the shift register at 0, and all outputs at 0.
- **IDLE:**
  - `BIT_STB & WORD_STB`: sample `SER_DATA` as bit 0, set the counter to 1, and go to SHIFT.
  - `BIT_STB` without `WORD_STB`: ignored.
- **SHIFT:**
  - Each `BIT_STB` shifts `SER_DATA` in at the LSB end and increments the counter.
  - Number of bits per frame, N: WIDTH, or WIDTH+1 when parity is enabled. The last bit is the parity bit.
  - When bit N is sampled, the word completes and the FSM returns to IDLE.
- **`WORD_STB` while in SHIFT:**
  - Set `FRAME_ERR`.
  - Discard the partial word.
  - Restart: the coincident bit becomes bit 0, and the FSM stays in SHIFT with the counter at 1.
- **Word completion, next cycle (a minus sign means a don't-care condition):**
  - `WORD_VALID`=0: load `WORD`, set `WORD_VALID`.
  - `WORD_VALID`=1, `WORD_ACK`=1 in the completion cycle: load the new word; `WORD_VALID` stays 1.
  - `WORD_VALID`=1, `WORD_ACK`=0: drop the new word, set `OVERRUN`; `WORD` is unchanged.
- `WORD_ACK` with no completion clears `WORD_VALID`. `WORD_ACK` while `WORD_VALID`=0 has no effect.
- `ERR_CLR` clears all sticky flags. If a set event occurs in the same cycle, the set wins.
- `BIT_STB` asserted on consecutive cycles is legal; each cycle is one bit.

## Timing

- Latency: `WORD`/`WORD_VALID` update on the clock edge after the edge that sampled bit N, i.e. 1 cycle.
- `OVERRUN`, `FRAME_ERR`, and `PAR_ERR` set on the same edge as the event that causes them.
- Asserting `SIM_RST` mid-word clears all state immediately. There is no partial-word output.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration

- `SD_PARITY_EN` defined:
  - N = WIDTH+1.
  - The parity bit is chosen so the count of ones over all N bits is odd.
  - On mismatch, `PAR_ERR` is set and the word is still delivered.
- `SD_PARITY_EN` undefined:
  - N = WIDTH.
  - The `PAR_ERR` port and the parity logic are absent.

## Structure

- Package `sd_pkg` holds:
  - the FSM state enum (`SD_IDLE`, `SD_SHIFT`);
  - the default word-width constant `SD_WORD_BITS` = 26;
  - the counter width function (clog2 of WIDTH+2).
- One sub-module, `sd_shift_reg`, contains the serial-in shift register and bit counter, with load/clear controls. The FSM, holding register, handshake, and flags live in `sd_receiver`.

## Test plan

- **Basic word:**
  - Stimulus: WIDTH=26, no parity. Send 0x2AAAAAA MSB-first, with `BIT_STB` every 4 cycles and `WORD_STB` on the first bit.
  - Required response: `WORD`=0x2AAAAAA and `WORD_VALID`=1 one cycle after bit 26. `WORD_ACK` then clears `WORD_VALID` on the next edge.
- **Overrun:**
  - Stimulus: deliver 0x0000001 without ack, then 0x3FFFFFF.
  - Required response: `WORD` stays 0x0000001 and `OVERRUN`=1. `ERR_CLR` then clears `OVERRUN`.
- **Simultaneous ack and completion:**
  - Stimulus: `WORD_ACK` in the completion cycle of the second word.
  - Required response: `WORD` holds the second word, `WORD_VALID` stays 1, and `OVERRUN`=0.
- **Frame restart:**
  - Stimulus: `WORD_STB` at bit 10, then 26 further bits of 0x1234567.
  - Required response: `FRAME_ERR`=1 and `WORD`=0x1234567.
- **Parity (`SD_PARITY_EN`):**
  - Stimulus: send 0x0000003 with parity bit 1, then send it again with parity bit 0.
  - Required response: `PAR_ERR` stays 0 for the first word and is set by the second.
- **Reset:**
  - Stimulus: assert `SIM_RST` after bit 13.
  - Required response: all outputs are 0 immediately. A subsequent clean word is received correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the LVDA/LVDC serial-data receiver.
package sd_pkg;
    typedef enum logic {
        SD_IDLE  = 1'b0,
        SD_SHIFT = 1'b1
    } sd_state_t;

    localparam int SD_WORD_BITS = 26;

    function automatic int sd_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction
endpackage

// File: rtl/sd_shift_reg.sv
// Serial-in shift register and bit counter. A load starts a new frame and
// takes priority over clear.
module sd_shift_reg #(
    parameter int NBITS = 26,
    parameter int CW    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [NBITS-1:0] o_data,
    output logic [CW-1:0]    o_cnt
);
    logic [NBITS-1:0] r_data;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= {{(NBITS-1){1'b0}}, i_bit};
            r_cnt  <= CW'(1);
        end else if (i_shift) begin
            r_data <= {r_data[NBITS-2:0], i_bit};
            r_cnt  <= r_cnt + 1'b1;
        end else if (i_clear) begin
            r_data <= '0;
            r_cnt  <= '0;
        end
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;
endmodule

// File: rtl/sd_receiver.sv
// Serial-data receiver: MSB-first word assembly, one-deep holding register
// with valid/ack handshake, sticky error flags. Odd parity with SD_PARITY_EN.
module sd_receiver
    import sd_pkg::*;
#(
    parameter int WIDTH = SD_WORD_BITS
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             SER_DATA,
    input  logic             BIT_STB,
    input  logic             WORD_STB,
    input  logic             WORD_ACK,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] WORD,
    output logic             WORD_VALID,
    output logic             OVERRUN,
    output logic             FRAME_ERR
`ifdef SD_PARITY_EN
    ,
    output logic             PAR_ERR
`endif
);
`ifdef SD_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = sd_cnt_w(WIDTH);

    sd_state_t        r_state;
    logic             r_done;
    logic [N-1:0]     w_sr;
    logic [CW-1:0]    w_cnt;
    logic             w_start;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_word;

    assign w_start = BIT_STB & WORD_STB;
    assign w_shift = BIT_STB & ~WORD_STB & (r_state == SD_SHIFT);
    assign w_last  = w_shift & (w_cnt == CW'(N - 1));

    // The counter is cleared on the same edge the holding register reads the
    // completed frame, so the word is still intact for that load.
    sd_shift_reg #(.NBITS(N), .CW(CW)) u_sr (
        .i_clk   (SIM_CLK),
        .i_rst   (SIM_RST),
        .i_clear (r_done),
        .i_load  (w_start),
        .i_shift (w_shift),
        .i_bit   (SER_DATA),
        .o_data  (w_sr),
        .o_cnt   (w_cnt)
    );

`ifdef SD_PARITY_EN
    assign w_word = w_sr[N-1:1];
`else
    assign w_word = w_sr;
`endif

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_state   <= SD_IDLE;
            r_done    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                SD_IDLE:  if (w_start) r_state <= SD_SHIFT;
                SD_SHIFT: if (w_last)  r_state <= SD_IDLE;
                default:  r_state <= SD_IDLE;
            endcase
            if (w_start && r_state == SD_SHIFT) FRAME_ERR <= 1'b1;
            else if (ERR_CLR)                   FRAME_ERR <= 1'b0;
        end
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            WORD       <= '0;
            WORD_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
`ifdef SD_PARITY_EN
            PAR_ERR    <= 1'b0;
`endif
        end else begin
            if (r_done && (!WORD_VALID || WORD_ACK)) begin
                WORD       <= w_word;
                WORD_VALID <= 1'b1;
            end else if (WORD_ACK) begin
                WORD_VALID <= 1'b0;
            end
            if (r_done && WORD_VALID && !WORD_ACK) OVERRUN <= 1'b1;
            else if (ERR_CLR)                      OVERRUN <= 1'b0;
`ifdef SD_PARITY_EN
            // Odd parity: total ones over data plus parity bit must be odd.
            if (r_done && !(^w_sr)) PAR_ERR <= 1'b1;
            else if (ERR_CLR)       PAR_ERR <= 1'b0;
`endif
        end
    end
endmodule
